bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-add-3 / double-dabble, one bit per clock) that feeds the per-digit seven-segment decoders on the board's HEX displays. It takes a register, PC or ALU value from the MIPS datapath on a start strobe. It then produces packed 4-bit decimal digits plus a leading-zero mask, so each decoder receives a value in 0..9 and blank digits can be forced off.

## Interface
- WIDTH, 16: binary input width; legal range 4..32.
- DIGITS, 5: BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH - 1; instantiating outside this is illegal.
- clk  in  1: single clock; all state changes on rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request conversion of `bin`; sampled only when idle.
- bin  in  WIDTH: unsigned value, captured on the accepted start edge.
- busy  out  1: high while a conversion is in progress.
- done  out  1: one-cycle pulse when `bcd`/`lz_mask` are updated.
- bcd  out  4*DIGITS: digit i in bits [4i+3:4i], digit 0 least significant; held between conversions.
- lz_mask  out  DIGITS: bit i = 1 when digit i is a leading zero; bit 0 is always 0.

## Operation
- States: IDLE, SHIFT. Encoding 1 bit; no other states.
- IDLE: busy=0. If start=1 at an edge:
  - load shift register with `bin`;
  - clear BCD scratch;
  - bit counter = WIDTH;
  - go to SHIFT.
- SHIFT: each edge performs one iteration:
  - every scratch digit >= 5 gets +3 (4-bit, no carry between digits);
  - then {scratch, shreg} shifts left 1;
  - counter decrements.
- On the iteration where counter reaches 0:
  - copy scratch to `bcd`;
  - compute `lz_mask`;
  - done=1 next cycle;
  - return to IDLE.
- lz_mask: bit i set iff digit i and all digits above it are 0, for i >= 1; value 0 gives lz_mask = all ones except bit 0.
- start while busy=1: ignored, no queueing; `bin` changes while busy have no effect.
- start high in the cycle done=1: accepted (state is IDLE); bcd keeps the previous result until the new done.
- Top-digit adjust never overflows given the DIGITS constraint; no overflow output.
- rst (any state, including mid-conversion): state IDLE, busy=0, done=0, bcd=0, lz_mask = all ones except bit 0, scratch/counter cleared; the in-flight conversion is discarded.

## Timing
- Reset values: busy 0, done 0, bcd 0, lz_mask {DIGITS-1{1'b1}, 1'b0}.
- Edge E0 samples start=1 in IDLE; busy=1 from after E0.
- Iterations occur on edges E1..E_WIDTH.
- After E_WIDTH: bcd/lz_mask valid, done=1, busy=0; done drops after E_WIDTH+1.
- Latency start-edge to done-visible: WIDTH cycles (16 at default).
- Throughput: one conversion per WIDTH+1 cycles when start is held high.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `disp_pkg`:
  - state enum (IDLE, SHIFT);
  - BCD_DIGIT_W = 4;
  - ADJ_THRESHOLD = 5 and ADJ_ADD = 3;
  - blank-mask reset constant helper.
- Combinational sub-module `bcd_digit_adj`: 4-bit in, 4-bit out, d >= 5 ? d+3 : d. Instantiated DIGITS times by generate.
- Top module holds the FSM, counter ($clog2(WIDTH+1) bits), shift register, scratch and output registers.
- Downstream, each `bcd` nibble drives one seven-segment decoder; `lz_mask` gates blanking.

## Test plan
- Zero: after reset, start with bin=0 -> done after 16 cycles; bcd=20'h00000, lz_mask=5'b11110.
- Typical: bin=1234 -> bcd=20'h01234, lz_mask=5'b10000; busy high exactly 16 cycles.
- Maximum: bin=16'hFFFF -> bcd=20'h65535, lz_mask=5'b00000.
- Ignored start: start for 9 (bin=9) then start with bin=500 at cycle 5 while busy -> single done, bcd=20'h00009.
- Back-to-back: start held high with bin=42, then 7 -> done pulses 17 cycles apart; results 20'h00042 then 20'h00007.
- Mid-op reset: rst at cycle 8 of a conversion -> next cycle busy=0, done=0, bcd=0; no done pulse follows.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared display types and constants for the HEX-display path: FSM states, BCD digit geometry
// and helpers used to validate and reset the converter.
package disp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned BCD_DIGIT_W   = 4;
    localparam int unsigned ADJ_THRESHOLD = 5;
    localparam int unsigned ADJ_ADD       = 3;

    // Every digit above the least significant one flagged as a leading zero.
    function automatic logic [31:0] blank_mask(input int unsigned digits);
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) begin
            if (i < digits) m[i] = 1'b1;
        end
        return m;
    endfunction

    // True when DIGITS decimal digits can represent every WIDTH-bit unsigned value.
    function automatic logic digits_ok(input int unsigned width, input int unsigned digits);
        longint unsigned p;
        longint unsigned maxv;
        p    = 64'd1;
        maxv = (64'd1 << width) - 64'd1;
        for (int i = 0; i < 20; i++) begin
            if ((i < int'(digits)) && (p <= maxv)) p = p * 64'd10;
        end
        return p > maxv;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: values of five or more get three added so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import disp_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= BCD_DIGIT_W'(ADJ_THRESHOLD))
                   ? i_digit + BCD_DIGIT_W'(ADJ_ADD)
                   : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, with a leading-zero mask so the
// seven-segment decoders downstream can blank unused digits.
module bin_to_bcd_seq
    import disp_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]             lz_mask
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam logic [DIGITS-1:0] LZ_RST = DIGITS'(blank_mask(DIGITS));

    if ((WIDTH < 4) || (WIDTH > 32) || !digits_ok(WIDTH, DIGITS)) begin : g_bad_params
        $error("bin_to_bcd_seq: illegal WIDTH/DIGITS combination");
    end

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic [DIGITS-1:0]  r_lz;
    logic               r_done;

    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W+WIDTH-1:0] w_cat;
    logic [BCD_W-1:0]       w_scratch_shift;
    logic [WIDTH-1:0]       w_shreg_shift;
    logic                   w_last;
    logic [DIGITS-1:0]      w_lz_nxt;
    logic                   w_zero_above;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The adjusted top digit never reaches 8 given the DIGITS constraint, so the dropped
    // bit of the shift is always zero.
    assign w_cat           = {w_adj, r_shreg} << 1;
    assign w_scratch_shift = w_cat[WIDTH +: BCD_W];
    assign w_shreg_shift   = w_cat[WIDTH-1:0];
    assign w_last          = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

    always_comb begin
        w_lz_nxt     = '0;
        w_zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above &
                           (w_scratch_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            w_lz_nxt[i]  = w_zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (start)  w_state_nxt = SHIFT;
            SHIFT: if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_lz      <= LZ_RST;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (r_state == IDLE) begin
                if (start) begin
                    r_shreg   <= bin;
                    r_scratch <= '0;
                    r_cnt     <= CNT_W'(WIDTH);
                end
            end else begin
                r_shreg   <= w_shreg_shift;
                r_scratch <= w_scratch_shift;
                r_cnt     <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_bcd <= w_scratch_shift;
                    r_lz  <= w_lz_nxt;
                end
            end
        end
    end

    assign done    = r_done;
    assign bcd     = r_bcd;
    assign lz_mask = r_lz;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: expected digits come from a decimal-division model and are
// queued at start, then popped and compared whenever the converter pulses done.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [19:0] bcd;
        logic [4:0]  lz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  lz_mask;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    int   prev_done_cyc = 0;
    exp_t sb[$];
    exp_t e_mon;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd),
        .lz_mask (lz_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] bcd_model(input int unsigned v);
        logic [19:0] b;
        int unsigned x;
        x = v;
        for (int i = 0; i < 5; i++) begin
            b[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return b;
    endfunction

    function automatic logic [4:0] lz_model(input logic [19:0] b);
        logic [4:0] m;
        m = '0;
        for (int i = 4; i >= 1; i--) begin
            if (b[i*4 +: 4] != 4'd0) break;
            m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic exp_t model(input int unsigned v);
        exp_t e;
        e.bcd = bcd_model(v);
        e.lz  = lz_model(e.bcd);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input logic [15:0] v, input bit push);
        bin   = v;
        start = 1'b1;
        if (push) sb.push_back(model(v));
        tick();
        start = 1'b0;
    endtask

    // Returns cycles from the accepted start edge until done is visible, and busy-high samples.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 60) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL done_unexpected observed=done expected=no_done");
            end
            if (sb.size() > 0) begin
                e_mon = sb.pop_front();
                checks++;
                assert (bcd === e_mon.bcd) else begin
                    errors++;
                    $error("FAIL sb_bcd observed=%h expected=%h", bcd, e_mon.bcd);
                end
                checks++;
                assert (lz_mask === e_mon.lz) else begin
                    errors++;
                    $error("FAIL sb_lz observed=%b expected=%b", lz_mask, e_mon.lz);
                end
            end
        end
    end

    initial begin
        int lat;
        int nb;
        int base;
        logic [15:0] rv;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_lz", 32'(lz_mask), 32'b11110);

        // Zero, with latency and busy-width checks
        start_conv(16'd0, 1'b1);
        wait_done(lat, nb);
        chk("zero_latency", lat, 32'd16);
        chk("zero_busy_cycles", nb, 32'd16);
        chk("zero_busy_at_done", 32'(busy), 32'd0);
        tick();
        chk("zero_done_width", 32'(done), 32'd0);

        // Typical
        start_conv(16'd1234, 1'b1);
        wait_done(lat, nb);
        chk("typ_latency", lat, 32'd16);
        chk("typ_busy_cycles", nb, 32'd16);
        tick();

        // Maximum
        start_conv(16'hFFFF, 1'b1);
        wait_done(lat, nb);
        chk("max_latency", lat, 32'd16);
        tick();

        // Start while busy is ignored
        base = done_cnt;
        start_conv(16'd9, 1'b1);
        repeat (4) tick();
        bin   = 16'd500;
        start = 1'b1;
        tick();
        start = 1'b0;
        bin   = 16'd0;
        wait_done(lat, nb);
        repeat (25) tick();
        chk("ignored_single_done", done_cnt - base, 32'd1);

        // Back-to-back with start held high
        base  = done_cnt;
        bin   = 16'd42;
        start = 1'b1;
        sb.push_back(model(42));
        tick();
        bin = 16'd7;
        sb.push_back(model(7));
        wait_done(lat, nb);
        tick();
        chk("b2b_done_width", 32'(done), 32'd0);
        chk("b2b_bcd_held", 32'(bcd), 32'(bcd_model(42)));
        chk("b2b_busy_restart", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(lat, nb);
        tick();
        chk("b2b_spacing", last_done_cyc - prev_done_cyc, 32'd17);
        chk("b2b_count", done_cnt - base, 32'd2);

        // Reset mid-conversion discards the result
        start_conv(16'd777, 1'b0);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_bcd", 32'(bcd), 32'h0);
        chk("midrst_lz", 32'(lz_mask), 32'b11110);
        rst  = 1'b0;
        base = done_cnt;
        repeat (30) tick();
        chk("midrst_no_done", done_cnt - base, 32'd0);

        // Recovery plus a few random values
        start_conv(16'd4321, 1'b1);
        wait_done(lat, nb);
        tick();
        for (int k = 0; k < 4; k++) begin
            rv = 16'($urandom_range(0, 65535));
            start_conv(rv, 1'b1);
            wait_done(lat, nb);
            chk("rand_latency", lat, 32'd16);
            tick();
        end

        repeat (3) tick();
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
